// File: rtl/tx_beamformer_pkg.sv
// Purpose: shared state encoding, default widths and burst-length helper for the TX beamformer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tx_bf_pkg;

    localparam int DEF_NUM_CHANNELS = 16;
    localparam int DEF_DELAY_WIDTH  = 8;
    localparam int DEF_HP_WIDTH     = 8;
    localparam int DEF_NC_WIDTH     = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_FIRE = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Burst length in clk cycles: two half-waves per period, nc periods.
    function automatic logic [DEF_HP_WIDTH+DEF_NC_WIDTH:0] burst_len(
        input logic [DEF_HP_WIDTH-1:0] hp,
        input logic [DEF_NC_WIDTH-1:0] nc
    );
        logic [DEF_HP_WIDTH+DEF_NC_WIDTH:0] hp_w;
        logic [DEF_HP_WIDTH+DEF_NC_WIDTH:0] nc_w;
        hp_w = {{(DEF_NC_WIDTH+1){1'b0}}, hp};
        nc_w = {{(DEF_HP_WIDTH+1){1'b0}}, nc};
        return (hp_w * nc_w) << 1;
    endfunction

endpackage

// File: rtl/tx_beamformer_if.sv
// Purpose: bundles the firing-controller config side and the pulser/status side of the TX beamformer.
// Latency: n/a (wiring only).
// Backpressure: none; start is a level request sampled only when the beamformer is idle.
// Ports: master = firing controller (drives start/config, observes drives/status);
//        slave  = tx_beamformer (observes start/config, drives tx_p/tx_n/tx_active/status).
interface tx_bf_if #(
    parameter int NUM_CHANNELS = 16,
    parameter int DELAY_WIDTH  = 8,
    parameter int HP_WIDTH     = 8,
    parameter int NC_WIDTH     = 4
);
    logic                                start;
    logic [NUM_CHANNELS*DELAY_WIDTH-1:0] delay_flat;
    logic [HP_WIDTH-1:0]                 half_period;
    logic [NC_WIDTH-1:0]                 num_cycles;
    logic [NUM_CHANNELS-1:0]             tx_p;
    logic [NUM_CHANNELS-1:0]             tx_n;
    logic [NUM_CHANNELS-1:0]             tx_active;
    logic                                busy;
    logic                                done;
    logic                                rx_start;
    logic                                err;
    logic [1:0]                          debug_state;

    modport master (
        output start, delay_flat, half_period, num_cycles,
        input  tx_p, tx_n, tx_active, busy, done, rx_start, err, debug_state
    );

    modport slave (
        input  start, delay_flat, half_period, num_cycles,
        output tx_p, tx_n, tx_active, busy, done, rx_start, err, debug_state
    );
endinterface

// File: rtl/tx_beamformer_pulse_gen.sv
// Purpose: one element's bipolar burst: hp cycles tx_p, hp cycles tx_n, repeated nc times, no gaps.
// Latency: drives start on the edge where fire is seen; finished asserts combinationally on the last burst cycle.
// Backpressure: none; fire while already bursting is ignored.
// Ports: clear drops the sticky finished flag; enable&fire launch the burst; hp/nc must be stable during the burst.
module tx_pulse_gen #(
    parameter int HP_WIDTH = 8,
    parameter int NC_WIDTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                enable,
    input  logic                fire,
    input  logic [HP_WIDTH-1:0] half_period,
    input  logic [NC_WIDTH-1:0] num_cycles,
    output logic                tx_p,
    output logic                tx_n,
    output logic                active,
    output logic                finished
);
    logic                phase_q;   // 0 = positive half, 1 = negative half
    logic [HP_WIDTH-1:0] hp_cnt;    // cycles spent in the current half, 1..hp
    logic [NC_WIDTH-1:0] cyc_cnt;   // completed full periods
    logic                fin_q;
    logic                ending;

    // True during the final cycle of the burst, so the top can leave FIRE on the very next edge.
    always_comb begin
        ending = active && phase_q && (hp_cnt == half_period)
                 && (cyc_cnt == num_cycles - NC_WIDTH'(1));
    end

    assign finished = fin_q | ending;

    always_ff @(posedge clk) begin
        if (reset) begin
            active  <= 1'b0;
            phase_q <= 1'b0;
            hp_cnt  <= '0;
            cyc_cnt <= '0;
            fin_q   <= 1'b0;
            tx_p    <= 1'b0;
            tx_n    <= 1'b0;
        end else begin
            if (clear) begin
                fin_q <= 1'b0;
            end
            if (active) begin
                if (hp_cnt == half_period) begin
                    hp_cnt <= HP_WIDTH'(1);
                    if (!phase_q) begin
                        phase_q <= 1'b1;
                        tx_p    <= 1'b0;
                        tx_n    <= 1'b1;
                    end else if (ending) begin
                        active  <= 1'b0;
                        phase_q <= 1'b0;
                        tx_n    <= 1'b0;
                        fin_q   <= 1'b1;
                    end else begin
                        phase_q <= 1'b0;
                        cyc_cnt <= cyc_cnt + NC_WIDTH'(1);
                        tx_p    <= 1'b1;
                        tx_n    <= 1'b0;
                    end
                end else begin
                    hp_cnt <= hp_cnt + HP_WIDTH'(1);
                end
            end else if (enable && fire) begin
                active  <= 1'b1;
                phase_q <= 1'b0;
                hp_cnt  <= HP_WIDTH'(1);
                cyc_cnt <= '0;
                tx_p    <= 1'b1;
                tx_n    <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/tx_beamformer.sv
// Purpose: fires a delayed bipolar burst per element, then pulses rx_start to open the receive window.
// Latency: start in cycle 0 -> ARM cycle 1 -> FIRE from cycle 2 -> DONE at 2 + max(delay) + 2*hp*nc.
// Backpressure: start is only sampled in IDLE; requests during a transaction are dropped.
// Ports: clk/reset (sync, active-high); bus.slave carries start/config in and tx_p/tx_n/tx_active/status out.
module tx_beamformer
    import tx_bf_pkg::*;
#(
    parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
    parameter int DELAY_WIDTH  = DEF_DELAY_WIDTH,
    parameter int HP_WIDTH     = DEF_HP_WIDTH,
    parameter int NC_WIDTH     = DEF_NC_WIDTH
) (
    input  logic    clk,
    input  logic    reset,
    tx_bf_if.slave  bus
);
    // Wide enough that t cannot wrap before the latest channel completes.
    localparam int T_WIDTH = DELAY_WIDTH + HP_WIDTH + NC_WIDTH + 1;

    state_t                              state_q, state_d;
    logic [NUM_CHANNELS*DELAY_WIDTH-1:0] delay_q;
    logic [HP_WIDTH-1:0]                 hp_q;
    logic [NC_WIDTH-1:0]                 nc_q;
    logic [T_WIDTH-1:0]                  t_q, t_next;
    logic                                cfg_bad, gen_en, clear, all_fin;
    logic [NUM_CHANNELS-1:0]             fire, fin, p_w, n_w, act_w;
    logic                                busy_d, done_d, rx_start_d, err_d;

    assign cfg_bad = (hp_q == '0) || (nc_q == '0);
    assign clear   = (state_q == ST_ARM);
    assign gen_en  = ((state_q == ST_ARM) && !cfg_bad) || (state_q == ST_FIRE);
    // Pulser outputs are registered, so launch against the timebase value of the next cycle.
    assign t_next  = (state_q == ST_ARM) ? '0 : t_q + T_WIDTH'(1);
    assign all_fin = &fin;

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        assign fire[i] = (t_next == T_WIDTH'(delay_q[i*DELAY_WIDTH +: DELAY_WIDTH]));

        tx_pulse_gen #(
            .HP_WIDTH (HP_WIDTH),
            .NC_WIDTH (NC_WIDTH)
        ) u_pg (
            .clk         (clk),
            .reset       (reset),
            .clear       (clear),
            .enable      (gen_en),
            .fire        (fire[i]),
            .half_period (hp_q),
            .num_cycles  (nc_q),
            .tx_p        (p_w[i]),
            .tx_n        (n_w[i]),
            .active      (act_w[i]),
            .finished    (fin[i])
        );
    end

    assign bus.tx_p        = p_w;
    assign bus.tx_n        = n_w;
    assign bus.tx_active   = act_w;
    assign bus.debug_state = state_q;

    // State, timebase, config latches and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            t_q          <= '0;
            delay_q      <= '0;
            hp_q         <= '0;
            nc_q         <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.rx_start <= 1'b0;
            bus.err      <= 1'b0;
        end else begin
            state_q      <= state_d;
            bus.busy     <= busy_d;
            bus.done     <= done_d;
            bus.rx_start <= rx_start_d;
            bus.err      <= err_d;
            if ((state_q == ST_IDLE) && bus.start) begin
                delay_q <= bus.delay_flat;
                hp_q    <= bus.half_period;
                nc_q    <= bus.num_cycles;
            end
            if ((state_q == ST_ARM) || (state_q == ST_FIRE)) begin
                t_q <= t_next;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.start) state_d = ST_ARM;
            ST_ARM:  state_d = cfg_bad ? ST_DONE : ST_FIRE;
            ST_FIRE: if (all_fin) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Status values for the next cycle; registered above.
    always_comb begin
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);
        rx_start_d = (state_q == ST_FIRE) && all_fin;
        err_d      = (state_q == ST_ARM) && cfg_bad;
    end
endmodule

// File: tb/tb_tx_beamformer.sv
// Purpose: self-checking bench for tx_beamformer against a cycle-indexed reference of the burst timing.
// Latency: checks every cycle of each transaction from acceptance through the idle cycle after DONE.
// Backpressure: exercises ignored start pulses, config changes after acceptance and back-to-back firings.
module tb_tx_beamformer;
    import tx_bf_pkg::*;

    localparam int NCH = 16;
    localparam int DW  = 8;
    localparam int HPW = 8;
    localparam int NCW = 4;
    localparam int OW  = 3*NCH + 6;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tx_bf_if #(.NUM_CHANNELS(NCH), .DELAY_WIDTH(DW), .HP_WIDTH(HPW), .NC_WIDTH(NCW)) bus ();

    tx_beamformer #(.NUM_CHANNELS(NCH), .DELAY_WIDTH(DW), .HP_WIDTH(HPW), .NC_WIDTH(NCW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    // Configuration as the controller presented it at acceptance.
    int dly [NCH];
    int hp_m;
    int nc_m;

    function automatic int done_cycle();
        int maxd = 0;
        if (hp_m == 0 || nc_m == 0) return 2;
        foreach (dly[i]) if (dly[i] > maxd) maxd = dly[i];
        return 2 + maxd + 2*hp_m*nc_m;
    endfunction

    // Expected outputs k cycles after the start was sampled (k <= 0 means idle).
    function automatic logic [OW-1:0] model(int k);
        logic [NCH-1:0] p = '0, n = '0, a = '0;
        logic [1:0] st;
        int kd = done_cycle();
        int len = 2*hp_m*nc_m;
        bit bad = (hp_m == 0 || nc_m == 0);
        int rel;
        if (k == kd)                st = 2'd3;
        else if (k == 1)            st = 2'd1;
        else if (k > 1 && k < kd)   st = 2'd2;
        else                        st = 2'd0;
        if (!bad && k >= 1 && k <= kd) begin
            for (int i = 0; i < NCH; i++) begin
                rel = k - 2 - dly[i];
                if (rel >= 0 && rel < len) begin
                    a[i] = 1'b1;
                    if (((rel / hp_m) % 2) == 0) p[i] = 1'b1;
                    else                         n[i] = 1'b1;
                end
            end
        end
        return {p, n, a, (k >= 1 && k <= kd), (k == kd), (k == kd && !bad), (k == kd && bad), st};
    endfunction

    function automatic logic [OW-1:0] observed();
        return {bus.tx_p, bus.tx_n, bus.tx_active, bus.busy, bus.done, bus.rx_start, bus.err,
                bus.debug_state};
    endfunction

    task automatic check(input string tag, input int k);
        logic [OW-1:0] obs = observed();
        logic [OW-1:0] exp_v = model(k);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp_v);
        end
    endtask

    task automatic drive_cfg();
        for (int i = 0; i < NCH; i++) bus.delay_flat[i*DW +: DW] = DW'(dly[i]);
        bus.half_period = HPW'(hp_m);
        bus.num_cycles  = NCW'(nc_m);
    endtask

    task automatic scramble_inputs();
        bus.start       = 1'($urandom_range(0, 1));
        bus.delay_flat  = {4{$urandom()}} ;
        bus.half_period = HPW'($urandom_range(0, 255));
        bus.num_cycles  = NCW'($urandom_range(0, 15));
    endtask

    // Entered at the negedge of an idle cycle (cycle 0); leaves at the negedge of the idle cycle after DONE.
    task automatic run_txn(input string tag, input bit scramble, input bit hold);
        int kd = done_cycle();
        drive_cfg();
        bus.start = 1'b1;
        for (int k = 1; k <= kd + 1; k++) begin
            @(negedge clk);
            check(tag, k);
            if (k < kd) begin
                if (scramble) scramble_inputs();
                else          bus.start = 1'b0;
            end else if (k == kd) begin
                bus.start = hold;
            end else if (!hold) begin
                bus.start = 1'b0;
            end
        end
    endtask

    task automatic set_all(input int d, input int hp, input int nc);
        foreach (dly[i]) dly[i] = d;
        hp_m = hp;
        nc_m = nc;
    endtask

    task automatic set_ramp(input int hp, input int nc);
        foreach (dly[i]) dly[i] = 4*i;
        hp_m = hp;
        nc_m = nc;
    endtask

    task automatic set_random();
        foreach (dly[i]) dly[i] = $urandom_range(0, 63);
        hp_m = $urandom_range(1, 4);
        nc_m = $urandom_range(1, 3);
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            n_cmp++;
            assert ((bus.tx_p & bus.tx_n) === '0) else begin
                n_bad++;
                $error("FAIL overlap tx_p=%h tx_n=%h required no common bit", bus.tx_p, bus.tx_n);
            end
        end
    end

    initial begin
        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.delay_flat  = '0;
        bus.half_period = '0;
        bus.num_cycles  = '0;
        set_all(0, 1, 1);
        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        check("reset", 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_after_reset", 0);

        set_all(0, 2, 1);
        run_txn("all_zero_hp2_nc1", 1'b0, 1'b0);

        set_ramp(1, 2);
        run_txn("ramp_hp1_nc2", 1'b0, 1'b0);

        set_all(3, 0, 3);
        run_txn("err_hp0", 1'b0, 1'b0);
        set_all(3, 2, 0);
        run_txn("err_nc0", 1'b0, 1'b0);

        // Reset during the ramp burst: sampled at the end of cycle 10.
        set_ramp(1, 2);
        drive_cfg();
        bus.start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            check("mid_reset_pre", k);
            bus.start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        check("mid_reset_cycle11", 0);
        reset = 1'b0;
        @(negedge clk);
        check("mid_reset_idle", 0);
        run_txn("after_reset_ramp", 1'b0, 1'b0);

        foreach (dly[i]) dly[i] = 4*(NCH-1-i);
        hp_m = 2;
        nc_m = 1;
        run_txn("scrambled_inputs", 1'b1, 1'b0);

        set_random();
        run_txn("back2back_a", 1'b0, 1'b1);
        set_random();
        run_txn("back2back_b", 1'b0, 1'b1);
        set_all(5, 1, 1);
        run_txn("back2back_c", 1'b0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            set_random();
            run_txn($sformatf("random_%0d", r), 1'($urandom_range(0, 1)), 1'b0);
        end

        set_all(0, 3, 15);
        dly[0] = 255;
        run_txn("delay255_hp3_nc15", 1'b0, 1'b0);

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
